// File: rtl/cast_inject_arbiter_if.sv
// Bundle of signals between the local send buffers, the cast injection
// arbiter and the router's local cast input port.
//
// Signal names follow the arbiter's point of view:
//   req_valid_i / req_data_i / req_ready_o : per-source flit handshake
//   valid_o / data_o / ready_i             : injection handshake to the router
//   credit_upd_i                           : one downstream slot freed (pulse)
//   grant_o / credit_o / credit_err_o      : status
//
// Modports:
//   slave  - the arbiter itself
//   master - the surrounding environment (sources, router, credit return)
interface cast_inject_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DW      = 16,
  parameter int unsigned CW      = 4
);
  logic [NUM_REQ-1:0]    req_valid_i;
  logic [NUM_REQ*DW-1:0] req_data_i;
  logic [NUM_REQ-1:0]    req_ready_o;
  logic                  valid_o;
  logic [DW-1:0]         data_o;
  logic                  ready_i;
  logic                  credit_upd_i;
  logic [NUM_REQ-1:0]    grant_o;
  logic [CW-1:0]         credit_o;
  logic                  credit_err_o;

  modport slave (
    input  req_valid_i, req_data_i, ready_i, credit_upd_i,
    output req_ready_o, valid_o, data_o, grant_o, credit_o, credit_err_o
  );

  modport master (
    output req_valid_i, req_data_i, ready_i, credit_upd_i,
    input  req_ready_o, valid_o, data_o, grant_o, credit_o, credit_err_o
  );
endinterface

// File: rtl/cast_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one cast-network injection port
// among NUM_REQ local sources. A source wins only with a HEAD flit at its
// front, then owns the port until its TAIL transfers. A credit counter tracks
// free slots in the downstream receive FIFO; credit_upd_i returns one slot.
//
// Ports:
//   clk  - clock
//   rstn - asynchronous active-low reset
//   bus  - cast_inject_arbiter_if.slave (source handshakes, injection
//          handshake, credit return, grant/credit/error status)
//
// Flit type lives in data[DW-1:DW-2]; FLIT_HEAD/FLIT_TAIL must match the
// codes used by the rest of the network.
module cast_inject_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DW          = 16,
  parameter int unsigned CREDIT_INIT = 8,
  parameter int unsigned CW          = $clog2(CREDIT_INIT + 1),
  parameter logic [1:0]  FLIT_HEAD   = 2'b10,
  parameter logic [1:0]  FLIT_TAIL   = 2'b01
) (
  input logic                  clk,
  input logic                  rstn,
  cast_inject_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] CreditMax = CW'(CREDIT_INIT);

  typedef enum logic [0:0] {StIdle, StLock} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]      credit_q, credit_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] eligible;
  logic               win_found;
  logic [IW-1:0]      win_idx;
  int unsigned        scan_idx;
  logic [DW-1:0]      own_flit;
  logic               own_valid;
  logic               can_send;
  logic               xfer;

  // Only a valid HEAD may open a packet; anything else at the front stalls.
  always_comb begin
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      eligible[k] = bus.req_valid_i[k] && (bus.req_data_i[k*DW + DW - 2 +: 2] == FLIT_HEAD);
    end
  end

  // First eligible index at or after rr_ptr, wrapping at NUM_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NUM_REQ;
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(scan_idx);
      end
    end
  end

  // Owner's flit and valid, selected by the locked index.
  always_comb begin
    own_flit  = '0;
    own_valid = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (owner_q == IW'(k)) begin
        own_flit  = bus.req_data_i[k*DW +: DW];
        own_valid = bus.req_valid_i[k];
      end
    end
  end

  assign can_send = (credit_q != '0);
  assign xfer     = (state_q == StLock) && own_valid && can_send && bus.ready_i;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      credit_q <= CreditMax;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StLock;
          owner_d = win_idx;
          for (int unsigned k = 0; k < NUM_REQ; k++) begin
            grant_d[k] = (win_idx == IW'(k));
          end
        end
      end
      StLock: begin
        if (xfer && (own_flit[DW-1 -: 2] == FLIT_TAIL)) begin
          state_d  = StIdle;
          grant_d  = '0;
          rr_ptr_d = IW'((32'(owner_q) + 32'd1) % NUM_REQ);
        end
      end
      default: ;
    endcase
  end

  // Credit counter: a send and a return in the same cycle cancel. A return
  // with the counter already full is dropped and flagged.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    unique case ({xfer, bus.credit_upd_i})
      2'b10: credit_d = credit_q - CW'(1);
      2'b01: begin
        if (credit_q == CreditMax) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    bus.valid_o      = 1'b0;
    bus.data_o       = '0;
    bus.req_ready_o  = '0;
    bus.grant_o      = grant_q;
    bus.credit_o     = credit_q;
    bus.credit_err_o = err_q;
    if (state_q == StLock) begin
      bus.data_o  = own_flit;
      bus.valid_o = own_valid && can_send;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        bus.req_ready_o[k] = (owner_q == IW'(k)) && bus.ready_i && can_send;
      end
    end
  end

endmodule
